vldrdy_sink_check: RTL and testbench
====================================

Name: vldrdy_sink_check

Overview:
Synthesizable receiving end of a valid/ready stream. It is the reader counterpart to master_vldrdy and the downstream load for flow_8to16 / flow_16to8. It generates programmable back-pressure on src_rdy and checks received data against an incrementing sequence. It also checks handshake-protocol compliance and exposes transfer, error and first-error status for benches and on-chip self-test.

Parameters:
DWIDTH, 8, data width of src_data and the expected-value path
CNT_WIDTH, 16, width of the transfer and error counters
LFSR_SEED, 16'hACE1, non-zero seed loaded into the back-pressure LFSR

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active high
cfg_en  input  1  enable, active high; protocol may be violated while low
cfg_mode  input  2  ready mode: 0 always, 1 LFSR random, 2 fixed duty, 3 treated as 0
cfg_duty  input  4  ready density for modes 1 and 2 (0 = never ready, 15 = 15/16)
cfg_start_val  input  DWIDTH  first expected data word
src_val  input  1  valid, active high
src_rdy  output  1  ready, active high, registered
src_data  input  DWIDTH  data, must be steady while valid and not ready
read_counter  output  CNT_WIDTH  accepted transfers, saturating
err_counter  output  CNT_WIDTH  data mismatches, saturating
err_flag  output  1  sticky, set on first data mismatch
first_err_exp  output  DWIDTH  expected value at first mismatch
first_err_got  output  DWIDTH  received value at first mismatch
proto_err  output  1  sticky handshake-violation flag

Behaviour:
- Reset (rst=1 at a clk edge) drives every output to 0, clears the FSM to IDLE and loads the LFSR with LFSR_SEED. Reset mid-transfer abandons the transfer, which is not counted.
- Transfer occurs on a clk edge where src_val=1 and src_rdy=1.
- FSM states:
  - IDLE: src_rdy=0 and no checking.
  - IDLE->RUN when cfg_en=1. On that edge: expected value <= cfg_start_val; read_counter, err_counter, err_flag, first_err_* and proto_err clear; LFSR <= LFSR_SEED; phase counter <= 0.
  - RUN->IDLE when cfg_en=0. src_rdy goes low on that same edge.
  - A transfer sampled on the exit edge, when src_rdy was already high, is counted and checked.
- src_rdy is a register computed from mode and state only. There is no combinational path from src_val. First possible src_rdy=1 is the cycle after entering RUN.
- Ready modes, evaluated each RUN cycle for the next cycle:
  - Mode 0/3: src_rdy <= 1.
  - Mode 1: a 16-bit Galois LFSR (mask 16'hB400) advances every RUN cycle; src_rdy <= (lfsr[3:0] < cfg_duty).
  - Mode 2: a 4-bit phase counter increments every RUN cycle and wraps 15->0; src_rdy <= (phase < cfg_duty).
  - cfg_duty=0 gives a permanent stall in modes 1 and 2.
- Data check on each transfer:
  - Mismatch when src_data != expected.
  - After every transfer, expected <= src_data + 1 mod 2^DWIDTH. This resyncs, so a dropped word yields 1 error and a corrupted word yields 2.
  - On mismatch: err_counter++ (saturate at all-ones) and err_flag <= 1. If err_flag was 0, first_err_exp/first_err_got capture expected/src_data.
- read_counter increments on each transfer and saturates at 2^CNT_WIDTH-1.
- Protocol check (RUN only): register pend = src_val & ~src_rdy and the held data. proto_err <= 1 on a cycle where pend was 1 and either src_val=0 or src_data != held data. The check is ignored in IDLE and on the exit edge.
- Wrap-around: expected 8'hFF followed by 8'h00 is not an error.
- Outputs are stable between transfers. Status holds in IDLE until the next IDLE->RUN.

Test Plan:
- Reset, mode 0, cfg_start_val=8'h10, master sends 10,11,...,1F (16 words) -> src_rdy=1 from 2nd RUN cycle; read_counter=16, err_counter=0, err_flag=0, proto_err=0.
- Mode 0, sequence 00,01,03,04 (02 dropped) -> err_counter=1, first_err_exp=02, first_err_got=03, read_counter=4.
- Mode 0, sequence FD,FE,FF,00,01 with start FD -> wrap accepted, err_counter=0, read_counter=5.
- Mode 2, cfg_duty=4, src_val held high for 64 cycles -> src_rdy pattern 4 high / 12 low per 16 cycles; read_counter=16, data all correct.
- Mode 1, cfg_duty=8, master drops src_val while stalled (src_rdy=0) -> proto_err=1. Repeat with a data change while stalled -> proto_err=1. Same events with cfg_en=0 -> proto_err=0.
- Mode 0 streaming, assert rst mid-burst after 5 words -> next cycle src_rdy=0, all counters 0; re-enable with start 8'h00, send 00..03 -> read_counter=4, no errors.

Source files
------------

// File: rtl/vldrdy_sink_check.sv
// vldrdy_sink_check: valid/ready stream sink with programmable back-pressure, sequence check and protocol check
module vldrdy_sink_check #(
  parameter int          DWIDTH    = 8,
  parameter int          CNT_WIDTH = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_en,
  input  logic [1:0]           cfg_mode,
  input  logic [3:0]           cfg_duty,
  input  logic [DWIDTH-1:0]    cfg_start_val,
  input  logic                 src_val,
  output logic                 src_rdy,
  input  logic [DWIDTH-1:0]    src_data,
  output logic [CNT_WIDTH-1:0] read_counter,
  output logic [CNT_WIDTH-1:0] err_counter,
  output logic                 err_flag,
  output logic [DWIDTH-1:0]    first_err_exp,
  output logic [DWIDTH-1:0]    first_err_got,
  output logic                 proto_err
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic src_rdy_q, src_rdy_d, err_flag_q, err_flag_d, proto_err_q, proto_err_d, pend_q, pend_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [3:0] phase_q, phase_d;
  logic [DWIDTH-1:0] exp_q, exp_d, held_q, held_d;
  logic [DWIDTH-1:0] first_err_exp_q, first_err_exp_d, first_err_got_q, first_err_got_d;
  logic [CNT_WIDTH-1:0] read_counter_q, read_counter_d, err_counter_q, err_counter_d;
  logic run, enter, stay, xfer, mism, ready_next;
  always_comb begin
    run = state_q == RUN;
    enter = !run && cfg_en;
    stay = run && cfg_en;
    xfer = run && src_val && src_rdy_q;
    mism = xfer && (src_data != exp_q);
    ready_next = cfg_mode == 2'd1 ? lfsr_q[3:0] < cfg_duty :
                 cfg_mode == 2'd2 ? phase_q < cfg_duty : 1'b1;
    state_d = cfg_en ? RUN : IDLE;
    src_rdy_d = stay && ready_next;
    lfsr_d = enter ? LFSR_SEED :
             run ? ({1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000)) : lfsr_q;
    phase_d = enter ? 4'd0 : run ? phase_q + 4'd1 : phase_q;
    exp_d = enter ? cfg_start_val : xfer ? src_data + DWIDTH'(1) : exp_q;
    read_counter_d = enter ? '0 : read_counter_q + CNT_WIDTH'(xfer && !(&read_counter_q));
    err_counter_d = enter ? '0 : err_counter_q + CNT_WIDTH'(mism && !(&err_counter_q));
    err_flag_d = !enter && (err_flag_q || mism);
    first_err_exp_d = enter ? '0 : (mism && !err_flag_q) ? exp_q : first_err_exp_q;
    first_err_got_d = enter ? '0 : (mism && !err_flag_q) ? src_data : first_err_got_q;
    proto_err_d = !enter && (proto_err_q || (stay && pend_q && (!src_val || src_data != held_q)));
    pend_d = stay && src_val && !src_rdy_q;
    held_d = src_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      src_rdy_q <= 1'b0;
      lfsr_q <= LFSR_SEED;
      phase_q <= 4'd0;
      exp_q <= '0;
      held_q <= '0;
      pend_q <= 1'b0;
      read_counter_q <= '0;
      err_counter_q <= '0;
      err_flag_q <= 1'b0;
      first_err_exp_q <= '0;
      first_err_got_q <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      src_rdy_q <= src_rdy_d;
      lfsr_q <= lfsr_d;
      phase_q <= phase_d;
      exp_q <= exp_d;
      held_q <= held_d;
      pend_q <= pend_d;
      read_counter_q <= read_counter_d;
      err_counter_q <= err_counter_d;
      err_flag_q <= err_flag_d;
      first_err_exp_q <= first_err_exp_d;
      first_err_got_q <= first_err_got_d;
      proto_err_q <= proto_err_d;
    end
  end
  assign src_rdy = src_rdy_q;
  assign read_counter = read_counter_q;
  assign err_counter = err_counter_q;
  assign err_flag = err_flag_q;
  assign first_err_exp = first_err_exp_q;
  assign first_err_got = first_err_got_q;
  assign proto_err = proto_err_q;
endmodule

// File: tb/tb_vldrdy_sink_check.sv
// tb_vldrdy_sink_check: directed stimulus checked each cycle against a behavioural model plus literal expectations
module tb_vldrdy_sink_check;
  localparam logic [15:0] SEED = 16'hACE1;
  logic clk = 1'b0, rst, cfg_en, src_val, src_rdy, err_flag, proto_err;
  logic [1:0] cfg_mode;
  logic [3:0] cfg_duty;
  logic [7:0] cfg_start_val, src_data, first_err_exp, first_err_got;
  logic [15:0] read_counter, err_counter;
  int vectors = 0, miscompares = 0;
  logic m_on = 1'b0, m_run, m_rdy, m_ef, m_pe, m_pend;
  int m_n;
  logic [7:0] m_exp, m_fexp, m_fgot, m_held;
  logic [15:0] m_rc, m_ec;

  vldrdy_sink_check dut (
    .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_mode(cfg_mode), .cfg_duty(cfg_duty),
    .cfg_start_val(cfg_start_val), .src_val(src_val), .src_rdy(src_rdy), .src_data(src_data),
    .read_counter(read_counter), .err_counter(err_counter), .err_flag(err_flag),
    .first_err_exp(first_err_exp), .first_err_got(first_err_got), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ready level for the cycle following the n-th clock edge spent in RUN
  function automatic logic want_rdy(input int n);
    logic [15:0] l;
    l = SEED;
    if (cfg_mode == 2'd1) begin
      for (int i = 0; i < n - 1; i++) l = (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
      return l[3:0] < cfg_duty;
    end
    if (cfg_mode == 2'd2) return ((n - 1) % 16) < int'(cfg_duty);
    return 1'b1;
  endfunction

  task automatic model_step();
    if (rst) begin
      m_on = 1'b1; m_run = 1'b0; m_n = 0; m_rdy = 1'b0; m_exp = 8'h00; m_rc = 16'h0; m_ec = 16'h0;
      m_ef = 1'b0; m_fexp = 8'h00; m_fgot = 8'h00; m_pe = 1'b0; m_pend = 1'b0; m_held = 8'h00;
    end else if (!m_run) begin
      if (cfg_en) begin
        m_run = 1'b1; m_n = 0; m_rdy = 1'b0; m_exp = cfg_start_val; m_rc = 16'h0; m_ec = 16'h0;
        m_ef = 1'b0; m_fexp = 8'h00; m_fgot = 8'h00; m_pe = 1'b0; m_pend = 1'b0;
      end
    end else begin
      if (src_val && m_rdy) begin
        if (src_data != m_exp) begin
          if (!m_ef) begin m_fexp = m_exp; m_fgot = src_data; end
          m_ef = 1'b1;
          if (m_ec != 16'hFFFF) m_ec = m_ec + 16'd1;
        end
        if (m_rc != 16'hFFFF) m_rc = m_rc + 16'd1;
        m_exp = src_data + 8'd1;
      end
      if (cfg_en && m_pend && (!src_val || src_data != m_held)) m_pe = 1'b1;
      m_pend = src_val && !m_rdy;
      m_held = src_data;
      m_n++;
      m_run = cfg_en;
      m_rdy = cfg_en && want_rdy(m_n);
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (m_on) begin
      chk("src_rdy", src_rdy, m_rdy);
      chk("read_counter", read_counter, m_rc);
      chk("err_counter", err_counter, m_ec);
      chk("err_flag", err_flag, m_ef);
      chk("first_err_exp", first_err_exp, m_fexp);
      chk("first_err_got", first_err_got, m_fgot);
      chk("proto_err", proto_err, m_pe);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", miscompares);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    logic r, ok;
    ok = 1'b0;
    src_val = 1'b1;
    src_data = d;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      r = src_rdy;
      tick();
      if (r) begin ok = 1'b1; break; end
    end
    chk("send_done", ok, 1'b1);
  endtask

  task automatic find_stall();
    for (int k = 0; k < 64; k++) begin
      if (!src_rdy) break;
      tick();
    end
  endtask

  initial begin
    logic r;
    logic [7:0] cur;
    rst = 1'b1; cfg_en = 1'b0; cfg_mode = 2'd0; cfg_duty = 4'd0; cfg_start_val = 8'h00;
    src_val = 1'b0; src_data = 8'h00;
    tick(); tick();
    rst = 1'b0;
    chk("rst_rdy", src_rdy, 1'b0);
    chk("rst_rc", read_counter, 16'd0);
    chk("rst_flag", err_flag, 1'b0);
    // in-order stream of 16 words
    cfg_start_val = 8'h10; cfg_en = 1'b1;
    tick();
    chk("run1_rdy", src_rdy, 1'b0);
    tick();
    chk("run2_rdy", src_rdy, 1'b1);
    for (int i = 0; i < 16; i++) send(8'h10 + 8'(i));
    src_val = 1'b0;
    tick();
    chk("t1_rc", read_counter, 16'd16);
    chk("t1_ec", err_counter, 16'd0);
    chk("t1_pe", proto_err, 1'b0);
    // dropped word
    cfg_en = 1'b0; tick();
    cfg_start_val = 8'h00; cfg_en = 1'b1; tick();
    send(8'h00); send(8'h01); send(8'h03); send(8'h04);
    src_val = 1'b0; tick();
    chk("t2_ec", err_counter, 16'd1);
    chk("t2_fexp", first_err_exp, 8'h02);
    chk("t2_fgot", first_err_got, 8'h03);
    chk("t2_rc", read_counter, 16'd4);
    cfg_en = 1'b0; tick(); tick();
    chk("t2_hold_ec", err_counter, 16'd1);
    chk("t2_hold_flag", err_flag, 1'b1);
    // wrap-around
    cfg_start_val = 8'hFD; cfg_en = 1'b1; tick();
    send(8'hFD); send(8'hFE); send(8'hFF); send(8'h00); send(8'h01);
    src_val = 1'b0; tick();
    chk("t3_ec", err_counter, 16'd0);
    chk("t3_rc", read_counter, 16'd5);
    cfg_en = 1'b0; tick();
    // fixed duty 4/16 with valid held high
    cfg_mode = 2'd2; cfg_duty = 4'd4; cfg_start_val = 8'h00; cfg_en = 1'b1; tick();
    cur = 8'h00;
    for (int i = 0; i < 64; i++) begin
      src_val = 1'b1; src_data = cur;
      @(negedge clk);
      r = src_rdy;
      tick();
      if (r) cur = cur + 8'd1;
    end
    chk("t4_rc", read_counter, 16'd16);
    chk("t4_words", cur, 8'd16);
    chk("t4_ec", err_counter, 16'd0);
    chk("t4_pe", proto_err, 1'b0);
    src_val = 1'b0; cfg_en = 1'b0; tick();
    // random back-pressure: valid dropped while stalled
    cfg_mode = 2'd1; cfg_duty = 4'd8; cfg_en = 1'b1; tick();
    repeat (20) tick();
    find_stall();
    src_val = 1'b1; src_data = 8'h55; tick();
    src_val = 1'b0; tick();
    chk("t5_drop_pe", proto_err, 1'b1);
    // data changed while stalled
    cfg_en = 1'b0; tick();
    cfg_en = 1'b1; tick();
    chk("t5_clear_pe", proto_err, 1'b0);
    find_stall();
    src_val = 1'b1; src_data = 8'h20; tick();
    src_data = 8'h21; tick();
    src_val = 1'b0; tick();
    chk("t5_data_pe", proto_err, 1'b1);
    // violation on the exit edge and in IDLE is ignored
    cfg_en = 1'b0; tick();
    cfg_en = 1'b1; tick();
    src_val = 1'b1; src_data = 8'h00; tick();
    cfg_en = 1'b0; src_val = 1'b0; tick();
    src_val = 1'b1; src_data = 8'h01; tick();
    src_val = 1'b0; tick();
    src_val = 1'b1; tick();
    src_data = 8'h02; tick();
    src_val = 1'b0; tick();
    chk("t5_idle_pe", proto_err, 1'b0);
    // reset mid-burst
    cfg_mode = 2'd0; cfg_start_val = 8'h00; cfg_en = 1'b1; tick();
    for (int i = 0; i < 5; i++) send(8'(i));
    src_val = 1'b1; src_data = 8'h05; rst = 1'b1; tick();
    chk("t6_rst_rdy", src_rdy, 1'b0);
    chk("t6_rst_rc", read_counter, 16'd0);
    chk("t6_rst_ec", err_counter, 16'd0);
    rst = 1'b0; src_val = 1'b0; tick();
    for (int i = 0; i < 4; i++) send(8'(i));
    src_val = 1'b0; tick();
    chk("t6_rc", read_counter, 16'd4);
    chk("t6_ec", err_counter, 16'd0);
    chk("t6_flag", err_flag, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
